dcache_ctrl: RTL
================

// Module: dcache_ctrl
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache between the core's 16-bit load/store port and d_mem.
//  Acts as initiator on the 64-bit line interface: issues re/we, holds addr/wdata, waits on mem_rdy.
//  One instance per core. Single outstanding memory op. Hits complete in 0 stall cycles.
// PARAMETERS
//  INDEX_W   6   index bits; 2**INDEX_W lines, TAG_W = 11 - INDEX_W
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   reset, asynchronous, active-low
//  cpu_addr     in   16  word address; [1:0] word-in-line, [INDEX_W+1:2] index, [12:INDEX_W+2] tag; [15:13] ignored
//  cpu_re       in   1   load request; held with addr until cpu_stall=0
//  cpu_we       in   1   store request; held with addr/wdata until cpu_stall=0
//  cpu_wdata    in   16  store data
//  cpu_rdata    out  16  load data, valid in cycle where cpu_re=1 and cpu_stall=0
//  cpu_stall    out  1   comb; 1 while request not yet serviced
//  mem_addr     out  11  line address to d_mem
//  mem_re       out  1   line read request, single-cycle pulse
//  mem_we       out  1   line write request, single-cycle pulse
//  mem_wdata    out  64  victim line, word w at [16w+15:16w]
//  mem_rd_data  in   64  fill line, sampled on edge ending the mem_rdy=1 cycle
//  mem_rdy      in   1   d_mem idle/complete
// BEHAVIOUR
//  Reset: state=COMPARE, all valid/dirty=0, mem_re=mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0; tags/data undefined.
//  Request = cpu_re|cpu_we; both set -> treated as store (cpu_rdata don't-care).
//  COMPARE: hit = valid[idx] & tag match. Hit or no request -> cpu_stall=0.
//   load hit: cpu_rdata = line word, comb. store hit: word written, dirty[idx]=1 at clk edge.
//   miss: cpu_stall=1; victim valid&dirty -> WB_ISSUE else FILL_ISSUE.
//  WB_ISSUE: when mem_rdy=1: mem_we=1 one cycle, mem_addr={victim tag,idx}, mem_wdata=victim line -> WB_WAIT.
//   mem_rdy=0: stay, no request driven.
//  WB_WAIT: mem_we=0; mem_addr/mem_wdata held stable; first mem_rdy=1 -> FILL_ISSUE.
//  FILL_ISSUE: when mem_rdy=1: mem_re=1 one cycle, mem_addr=cpu_addr[12:2] -> FILL_WAIT.
//  FILL_WAIT: mem_re=0, mem_addr held; on mem_rdy=1: line<=mem_rd_data, tag set, valid=1, dirty=0 -> COMPARE.
//  Retry in COMPARE then hits: miss cost = memory latency + 2 cycles per op (issue + COMPARE retry).
//  mem_re and mem_we never both 1; never asserted outside *_ISSUE; never while mem_rdy=0.
//  cpu_stall=1 in every state except COMPARE-with-hit/no-request.
//  Request dropped by core mid-miss (illegal): fill still completes, no store performed.
//  Reset mid-op: abort immediately, all lines invalid; dirty data lost (d_mem reset together).
//  Index/tag arithmetic purely bit slicing; no wrap logic; line address = {tag,index}.
// STRUCTURE
//  cache_pkg: typedef enum {COMPARE,WB_ISSUE,WB_WAIT,FILL_ISSUE,FILL_WAIT} cstate_t;
//   localparams LINE_W=64, WORD_W=16, MEM_AW=11, WORDS_PER_LINE=4.
//  Sub-module dcache_array: data/tag/valid/dirty storage, async read, sync word write,
//   sync line fill, valid/dirty clear on rst_n. dcache_ctrl holds SM and address/data regs.
// TESTING (d_mem as responder; init line i word0 = {i[6:0],1'b1,i[7:0]})
//  1 Cold load 0x0014 -> FILL mem_addr=0x005, no mem_we; cpu_rdata=0x0B05, stall drops 1 cycle after mem_rdy.
//  2 Store 0xBEEF to 0x0014, then load 0x0014 -> both hits, stall=0, rdata=0xBEEF, no mem_re/mem_we.
//  3 Load 0x0114 (same index, new tag) -> mem_we addr=0x005 wdata[15:0]=0xBEEF, then mem_re addr=0x045; rdata=0x8B45.
//  4 Load 0x0014 again -> clean victim: no mem_we; fill 0x005 returns 0xBEEF (write-back persisted).
//  5 cpu_re=cpu_we=1 to 0x0020 wdata 0x1234 -> treated as store; later load 0x0020 -> 0x1234.
//  6 rst_n low during FILL_WAIT -> mem_re/mem_we=0 at once; after release load 0x0014 misses (all invalid).
//  All tests: assertion mem_addr/mem_wdata stable from issue until mem_rdy, no request while mem_rdy=0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and widths for the direct-mapped write-back data cache.
package cache_pkg;
  typedef enum logic [2:0] {
    COMPARE,
    WB_ISSUE,
    WB_WAIT,
    FILL_ISSUE,
    FILL_WAIT
  } cstate_t;

  localparam int LINE_W         = 64;
  localparam int WORD_W         = 16;
  localparam int MEM_AW         = 11;
  localparam int WORDS_PER_LINE = 4;
endpackage

// File: rtl/dcache_array.sv
// Line storage: async read of data/tag/valid/dirty, sync word write and line fill.
module dcache_array import cache_pkg::*; #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = MEM_AW - INDEX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] idx,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [LINE_W-1:0]  rd_line,
  input  logic               word_we,
  input  logic [1:0]         word_sel,
  input  logic [WORD_W-1:0]  word_data,
  input  logic               fill_we,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [LINE_W-1:0]  fill_line
);
  localparam int NLINES = 1 << INDEX_W;

  logic [LINE_W-1:0] data_q [NLINES];
  logic [TAG_W-1:0]  tag_q  [NLINES];
  logic [NLINES-1:0] valid_q;
  logic [NLINES-1:0] dirty_q;

  assign rd_line  = data_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];

  // Data and tags carry no reset; only valid/dirty define a meaningful line.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[idx] <= fill_line;
      tag_q[idx]  <= fill_tag;
    end else if (word_we) begin
      data_q[idx][{word_sel, 4'b0000} +: WORD_W] <= word_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache controller; one outstanding line op to d_mem.
// Memory handshake: a request (mem_re or mem_we) is a one-cycle pulse raised only while mem_rdy=1;
// mem_addr/mem_wdata then stay stable until the next mem_rdy=1, which marks completion.
module dcache_ctrl import cache_pkg::*; #(
  parameter int INDEX_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         cpu_addr,
  input  logic                cpu_re,
  input  logic                cpu_we,
  input  logic [WORD_W-1:0]   cpu_wdata,
  output logic [WORD_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic                mem_re,
  output logic                mem_we,
  output logic [LINE_W-1:0]   mem_wdata,
  input  logic [LINE_W-1:0]   mem_rd_data,
  input  logic                mem_rdy,
  output cstate_t             dbg_state
);
  localparam int TAG_W = MEM_AW - INDEX_W;

  cstate_t             state, state_n;
  logic [MEM_AW-1:0]   addr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic                load_regs;

  logic [INDEX_W-1:0]  idx, arr_idx;
  logic [TAG_W-1:0]    tag, rd_tag;
  logic [1:0]          word_sel;
  logic                rd_valid, rd_dirty, hit, req;
  logic [LINE_W-1:0]   rd_line;
  logic [WORD_W-1:0]   rd_word;
  logic                word_we, fill_we;
  logic                unused_addr_hi;

  assign idx            = cpu_addr[INDEX_W+1:2];
  assign tag            = cpu_addr[12:INDEX_W+2];
  assign word_sel       = cpu_addr[1:0];
  assign unused_addr_hi = ^cpu_addr[15:13];
  assign req            = cpu_re | cpu_we;
  assign hit            = rd_valid && (rd_tag == tag);
  assign rd_word        = rd_line[{word_sel, 4'b0000} +: WORD_W];
  assign dbg_state      = state;

  // The fill targets the line latched at issue, not whatever the core presents now.
  assign arr_idx = (state == FILL_WAIT) ? addr_q[INDEX_W-1:0] : idx;

  dcache_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (arr_idx),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_line   (rd_line),
    .word_we   (word_we),
    .word_sel  (word_sel),
    .word_data (cpu_wdata),
    .fill_we   (fill_we),
    .fill_tag  (addr_q[MEM_AW-1:INDEX_W]),
    .fill_line (mem_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= COMPARE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_n;
      if (load_regs) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
    end
  end

  always_comb begin
    state_n   = state;
    cpu_stall = 1'b1;
    cpu_rdata = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    load_regs = 1'b0;
    word_we   = 1'b0;
    fill_we   = 1'b0;
    case (state)
      COMPARE: begin
        if (!req || hit) begin
          cpu_stall = 1'b0;
          word_we   = cpu_we;
          if (cpu_re && !cpu_we) cpu_rdata = rd_word;
        end else begin
          state_n = (rd_valid && rd_dirty) ? WB_ISSUE : FILL_ISSUE;
        end
      end
      WB_ISSUE: begin
        if (mem_rdy) begin
          mem_we    = 1'b1;
          mem_addr  = {rd_tag, idx};
          mem_wdata = rd_line;
          load_regs = 1'b1;
          state_n   = WB_WAIT;
        end
      end
      WB_WAIT: begin
        if (mem_rdy) state_n = FILL_ISSUE;
      end
      FILL_ISSUE: begin
        if (mem_rdy) begin
          mem_re    = 1'b1;
          mem_addr  = cpu_addr[12:2];
          load_regs = 1'b1;
          state_n   = FILL_WAIT;
        end
      end
      FILL_WAIT: begin
        if (mem_rdy) begin
          fill_we = 1'b1;
          state_n = COMPARE;
        end
      end
      default: state_n = COMPARE;
    endcase
  end
endmodule
